memory_pager: RTL and testbench
===============================

Name: memory_pager

Overview:
Parametrised successor to the 48K memory/divMMC block. It decodes Z80 memory and I/O cycles into a single external RAM address space that holds the ROMs, the 128K RAM banks and the divMMC RAM. It adds 128K paging (port 7FFD with lock) and a configurable divMMC page count. It also contains a 16KB internal dual-port video RAM that shadows banks 5 and 7 for the video generator.

Parameters:
MODEL, 1, 0 = 48K (port 7FFD ignored, behaves as register value 0); 1 = 128K paging enabled
DIVPAGES, 16, number of 8KB divMMC RAM pages; power of two, 4..32
RAMAW, 19, external RAM address width; fixed at 19 for the map below

Ports:
clock  in  1  system clock
reset  in  1  synchronous, active-low reset
ce  in  1  CPU clock enable; all CPU-side registers update only when ce=1
map  out  1  divMMC overlay active (conmem OR automap)
rfsh  in  1  Z80 /RFSH, active-low
mreq  in  1  Z80 /MREQ, active-low
iorq  in  1  Z80 /IORQ, active-low
rd  in  1  Z80 /RD, active-low
wr  in  1  Z80 /WR, active-low
m1  in  1  Z80 /M1, active-low
d  in  8  CPU data out
q  out  8  CPU data in (= ramQ)
a  in  16  CPU address
vce  in  1  video port clock enable
vq  out  8  video data
va  in  14  video address; va[13]=0 selects bank 5, va[13]=1 selects bank 7
ramRd  out  1  external RAM read strobe, active-low
ramWr  out  1  external RAM write strobe, active-low
ramD  out  8  external RAM write data (= d)
ramQ  in  8  external RAM read data
ramA  out  RAMAW  external RAM address

Behaviour:
- Registers and reset values (reset=0, sampled on clock with ce=1):
  - Port 7FFD fields: rampage[2:0]=0, scr=0, romsel=0, lock=0.
  - divMMC fields: conmem=0, mapram=0, divpage=0, automap=0, m1on=0.
  - With these values map=0 immediately after reset.
- Port 7FFD write (MODEL=1 only):
  - Decode: !iorq && !wr && !a[15] && !a[1] && !lock.
  - Loads rampage=d[2:0], scr=d[3], romsel=d[4], lock=d[5].
  - The write that sets lock still applies its other bits. lock is cleared only by reset.
  - scr is an output-free status bit; the top level reads it through a hierarchical-free port in the next revision. It has no effect here.
- Port E3 write:
  - Decode: !iorq && !wr && a[7:0]==E3.
  - Loads conmem=d[7] and divpage=d[log2(DIVPAGES)-1:0].
  - mapram <= mapram | d[6] (sticky until reset).
- Automap, evaluated on !mreq && !m1 (opcode fetch):
  - Trap addresses 0000, 0008, 0038, 0066, 04C6, 0562: m1on<=1 (delayed entry).
  - 1FF8-1FFF: m1on<=0 (delayed exit).
  - 3D00-3DFF, only when MODEL=0 or romsel=1: m1on<=1 and automap<=1 in the same cycle (immediate entry).
  - While m1=1: automap<=m1on, so a delayed change takes effect after the fetch cycle.
  - map = conmem | automap.
- External address map (19 bits), "bank" = 16KB:
  - 00000-1FFFF: RAM bank n at n*4000h.
  - 20000-27FFF: ROM n at 20000h+n*4000h.
  - 28000-29FFF: divMMC ROM.
  - 40000+p*2000h: divMMC RAM page p.
- CPU address decode:
  - 0000-1FFF, map=1, mapram=0: divMMC ROM, read-only.
  - 0000-1FFF, map=1, mapram=1: divMMC page 3, read-only.
  - 2000-3FFF, map=1: divMMC page divpage, read/write.
  - 0000-3FFF, map=0: ROM romsel (ROM 0 when MODEL=0), read-only.
  - 4000-7FFF: bank 5. 8000-BFFF: bank 2. C000-FFFF: bank rampage.
- Strobes (combinational):
  - ramRd = !(!mreq && !rd).
  - ramWr = !(!mreq && !wr && region writable).
  - Writes to read-only regions are suppressed, with no side effects.
- Video RAM:
  - The write port (ce) mirrors any CPU write to 4000-5FFF (vram[12:0]) and any write to bank 7 offset 0000-1FFF (vram[13]=1, only when rampage=7 and a=C000-DFFF).
  - Read port: vq valid one vce-qualified clock after va.
  - While !rfsh and a=4000-7FFF, the video address low 7 bits are replaced by a[6:0] (snow emulation).
- Reset mid-cycle: registers clear; decode follows the reset register values from the next clock.

Test Plan:
- Reset, then read 0000 -> ramA=20000h, ramRd=0, map=0; write 0000 -> ramWr stays 1.
- MODEL=1: OUT 7FFD,17h then read C000 -> ramA=1C000h and read 0000 -> ramA=24000h. OUT 7FFD,20h then OUT 7FFD,03h -> rampage stays 0.
- Fetch 0038 -> map stays 0 during the fetch and is 1 after m1 rises. Fetch 1FF8 -> map drops after that fetch. Fetch 3D12 with romsel=1 -> map=1 in the same cycle; with romsel=0 (MODEL=1) -> map=0.
- OUT E3,45h -> mapram=1, divpage=5; read 0100 -> ramA=46100h, write suppressed; write 2100 -> ramA=4A100h, ramWr=0. Then OUT E3,00h -> mapram still 1.
- Write 0AAh to 4123 -> vram[0123] updated, vq=0AAh one vce after va=0123h. With rampage=7, write to C010 -> vq=data at va=2010h.
- DIVPAGES=32: OUT E3,9Fh -> conmem=1, divpage=1Fh; write 2000 -> ramA=7E000h.

Source files
------------

// File: rtl/memory_pager.sv
`default_nettype none
// ============================================================================
//  Module      : memory_pager
//  Description : Z80 memory / I/O decoder for a Spectrum-style machine with
//                128K paging (port 7FFD with lock), divMMC overlay (port E3,
//                automap) and a 16KB dual-port video RAM shadowing the first
//                8KB of banks 5 and 7. All CPU memory is mapped into a single
//                19-bit external RAM space:
//                  00000-1FFFF  RAM banks 0..7 (16KB each)
//                  20000-27FFF  ROM 0 / ROM 1
//                  28000-29FFF  divMMC ROM
//                  40000+p*2000 divMMC RAM page p (8KB each)
//  Ports       : clock, reset (sync, active-low)
//                ce_i               CPU clock enable for all CPU-side state
//                rfsh_i..m1_i       Z80 bus controls (active-low)
//                a_i, d_i, q_o      CPU address / data out / data in
//                map_o              divMMC overlay active
//                vce_i, va_i, vq_o  video read port
//                ramRd_o, ramWr_o   external RAM strobes (active-low)
//                ramA_o, ramD_o,
//                ramQ_i             external RAM address / data
//  Revision    : 1.0 - initial parametrised release
// ============================================================================
module memory_pager #(
    parameter int MODEL    = 1,
    parameter int DIVPAGES = 16,
    parameter int RAMAW    = 19
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             ce_i,
    output logic             map_o,
    input  logic             rfsh_i,
    input  logic             mreq_i,
    input  logic             iorq_i,
    input  logic             rd_i,
    input  logic             wr_i,
    input  logic             m1_i,
    input  logic [7:0]       d_i,
    output logic [7:0]       q_o,
    input  logic [15:0]      a_i,
    input  logic             vce_i,
    output logic [7:0]       vq_o,
    input  logic [13:0]      va_i,
    output logic             ramRd_o,
    output logic             ramWr_o,
    output logic [7:0]       ramD_o,
    input  logic [7:0]       ramQ_i,
    output logic [RAMAW-1:0] ramA_o
);

    localparam int c_DPW = $clog2(DIVPAGES);

    // ------------------------------------------------------------------
    // CPU-side state
    // ------------------------------------------------------------------
    // The screen-select bit of 7FFD is accepted by the decode but not kept:
    // nothing in this block consumes it.
    logic [2:0]       rampage_q, rampage_d;
    logic             romsel_q,  romsel_d;
    logic             lock_q,    lock_d;
    logic             conmem_q,  conmem_d;
    logic             mapram_q,  mapram_d;
    logic [c_DPW-1:0] divpage_q, divpage_d;
    logic             automap_q, automap_d;
    logic             m1on_q,    m1on_d;

    logic w_wr_7ffd;
    logic w_wr_e3;
    logic w_fetch;
    logic w_trap;
    logic w_exit;
    logic w_rom3d;
    logic w_map;

    assign w_map = conmem_q | automap_q;
    assign map_o = w_map;

    assign w_wr_7ffd = (MODEL != 0) && !iorq_i && !wr_i && !a_i[15] && !a_i[1] && !lock_q;
    assign w_wr_e3   = !iorq_i && !wr_i && (a_i[7:0] == 8'hE3);
    assign w_fetch   = !mreq_i && !m1_i;

    assign w_trap = (a_i == 16'h0000) || (a_i == 16'h0008) || (a_i == 16'h0038) ||
                    (a_i == 16'h0066) || (a_i == 16'h04C6) || (a_i == 16'h0562);
    assign w_exit  = (a_i[15:3] == 13'h03FF);
    // The 3Dxx trap only fires while the 48K BASIC ROM is paged in.
    assign w_rom3d = (a_i[15:8] == 8'h3D) && ((MODEL == 0) || romsel_q);

    always_comb begin
        rampage_d = rampage_q;
        romsel_d  = romsel_q;
        lock_d    = lock_q;
        conmem_d  = conmem_q;
        mapram_d  = mapram_q;
        divpage_d = divpage_q;
        automap_d = automap_q;
        m1on_d    = m1on_q;

        if (w_wr_7ffd) begin
            rampage_d = d_i[2:0];
            romsel_d  = d_i[4];
            lock_d    = d_i[5];
        end

        if (w_wr_e3) begin
            conmem_d  = d_i[7];
            divpage_d = d_i[c_DPW-1:0];
            mapram_d  = mapram_q | d_i[6];
        end

        // Delayed traps only arm m1on during the fetch; automap follows it
        // once M1 goes high, so the trapped opcode itself still comes from
        // the normal ROM. The 3Dxx range switches in the same cycle.
        if (w_fetch) begin
            if (w_trap) begin
                m1on_d = 1'b1;
            end
            if (w_exit) begin
                m1on_d = 1'b0;
            end
            if (w_rom3d) begin
                m1on_d    = 1'b1;
                automap_d = 1'b1;
            end
        end else if (m1_i) begin
            automap_d = m1on_q;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            rampage_q <= '0;
            romsel_q  <= 1'b0;
            lock_q    <= 1'b0;
            conmem_q  <= 1'b0;
            mapram_q  <= 1'b0;
            divpage_q <= '0;
            automap_q <= 1'b0;
            m1on_q    <= 1'b0;
        end else if (ce_i) begin
            rampage_q <= rampage_d;
            romsel_q  <= romsel_d;
            lock_q    <= lock_d;
            conmem_q  <= conmem_d;
            mapram_q  <= mapram_d;
            divpage_q <= divpage_d;
            automap_q <= automap_d;
            m1on_q    <= m1on_d;
        end
    end

    // ------------------------------------------------------------------
    // CPU address -> external RAM address
    // ------------------------------------------------------------------
    logic [4:0]       w_page;
    logic [RAMAW-1:0] w_addr;
    logic             w_writable;

    assign w_page = 5'(divpage_q);

    always_comb begin
        w_addr     = '0;
        w_writable = 1'b1;
        unique case (a_i[15:14])
            2'b00: begin
                if (w_map) begin
                    if (!a_i[13]) begin
                        // Lower 8KB of the overlay is never writable; with
                        // mapram it shows page 3 instead of the divMMC ROM.
                        w_writable = 1'b0;
                        w_addr     = mapram_q ? {1'b1, 5'd3, a_i[12:0]}
                                              : {6'b010100, a_i[12:0]};
                    end else begin
                        w_addr = {1'b1, w_page, a_i[12:0]};
                    end
                end else begin
                    w_writable = 1'b0;
                    w_addr     = {4'b0100, romsel_q, a_i[13:0]};
                end
            end
            2'b01:   w_addr = {2'b00, 3'd5, a_i[13:0]};
            2'b10:   w_addr = {2'b00, 3'd2, a_i[13:0]};
            default: w_addr = {2'b00, rampage_q, a_i[13:0]};
        endcase
    end

    assign ramA_o  = w_addr;
    assign ramD_o  = d_i;
    assign q_o     = ramQ_i;
    assign ramRd_o = !(!mreq_i && !rd_i);
    assign ramWr_o = !(!mreq_i && !wr_i && w_writable);

    // ------------------------------------------------------------------
    // Video RAM: lower half shadows bank 5 0000-1FFF, upper half bank 7
    // ------------------------------------------------------------------
    logic [7:0]  vram_q [0:16383];
    logic [7:0]  vq_q;
    logic        w_vwr_b5;
    logic        w_vwr_b7;
    logic [13:0] w_vwaddr;
    logic [13:0] w_vraddr;

    assign w_vwr_b5 = !mreq_i && !wr_i && (a_i[15:13] == 3'b010);
    assign w_vwr_b7 = !mreq_i && !wr_i && (a_i[15:13] == 3'b110) && (rampage_q == 3'd7);
    assign w_vwaddr = {w_vwr_b7, a_i[12:0]};

    // During a refresh cycle that lands in contended memory the ULA fetch
    // picks up the refresh row on its low address bits ("snow").
    assign w_vraddr = (!rfsh_i && (a_i[15:14] == 2'b01)) ? {va_i[13:7], a_i[6:0]} : va_i;

    always_ff @(posedge clock) begin
        if (ce_i && (w_vwr_b5 || w_vwr_b7)) begin
            vram_q[w_vwaddr] <= d_i;
        end
    end

    always_ff @(posedge clock) begin
        if (vce_i) begin
            vq_q <= vram_q[w_vraddr];
        end
    end

    assign vq_o = vq_q;

endmodule
`default_nettype wire

// File: tb/tb_memory_pager.sv
`default_nettype none
// ============================================================================
//  Module      : tb_memory_pager
//  Description : Self-checking bench for memory_pager (MODEL=1, DIVPAGES=32).
//                Directed scenarios followed by randomized bus traffic checked
//                against a behavioural model of the paging rules.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_memory_pager;

    logic        clock = 1'b0;
    logic        reset, ce, rfsh, mreq, iorq, rd, wr, m1, vce;
    logic [7:0]  d, ramQ;
    logic [15:0] a;
    logic [13:0] va;
    logic        map, ramRd, ramWr;
    logic [7:0]  q, vq, ramD;
    logic [18:0] ramA;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clock = ~clock;

    memory_pager #(.MODEL(1), .DIVPAGES(32), .RAMAW(19)) dut (
        .clock(clock), .reset(reset), .ce_i(ce), .map_o(map),
        .rfsh_i(rfsh), .mreq_i(mreq), .iorq_i(iorq), .rd_i(rd), .wr_i(wr), .m1_i(m1),
        .d_i(d), .q_o(q), .a_i(a), .vce_i(vce), .vq_o(vq), .va_i(va),
        .ramRd_o(ramRd), .ramWr_o(ramWr), .ramD_o(ramD), .ramQ_i(ramQ), .ramA_o(ramA)
    );

    // ------------------------------------------------------------------
    // Behavioural reference model
    // ------------------------------------------------------------------
    int         m_rampage, m_romsel, m_lock, m_conmem, m_mapram, m_divpage;
    int         m_automap, m_m1on;
    logic [7:0] m_vram [16384];
    bit         m_vknown [16384];
    logic [7:0] m_vq;
    bit         m_vq_known;
    int         written_q[$];

    function automatic int exp_addr(input int ai);
        bit mp;
        mp = (m_conmem != 0) || (m_automap != 0);
        if (ai < 'h4000) begin
            if (mp && ai < 'h2000) return (m_mapram != 0) ? 'h40000 + 3 * 'h2000 + ai : 'h28000 + ai;
            if (mp) return 'h40000 + m_divpage * 'h2000 + (ai - 'h2000);
            return 'h20000 + m_romsel * 'h4000 + ai;
        end
        if (ai < 'h8000) return 5 * 'h4000 + (ai - 'h4000);
        if (ai < 'hC000) return 2 * 'h4000 + (ai - 'h8000);
        return m_rampage * 'h4000 + (ai - 'hC000);
    endfunction

    function automatic bit exp_writable(input int ai);
        bit mp;
        mp = (m_conmem != 0) || (m_automap != 0);
        return (ai >= 'h4000) || (mp && ai >= 'h2000);
    endfunction

    function automatic bit exp_map();
        return (m_conmem != 0) || (m_automap != 0);
    endfunction

    // Applies one rising clock edge to the model, using the inputs as driven.
    function automatic void model_step();
        int ai, vaddr, n_m1on, n_automap;
        ai        = int'(a);
        n_m1on    = m_m1on;
        n_automap = m_automap;
        if (vce) begin
            vaddr = int'(va);
            if (!rfsh && ai >= 'h4000 && ai < 'h8000) vaddr = (vaddr / 128) * 128 + ai % 128;
            m_vq       = m_vram[vaddr];
            m_vq_known = m_vknown[vaddr];
        end
        if (ce && !mreq && !wr) begin
            if (ai >= 'h4000 && ai < 'h6000) begin
                m_vram[ai - 'h4000] = d; m_vknown[ai - 'h4000] = 1'b1; written_q.push_back(ai - 'h4000);
            end
            if (m_rampage == 7 && ai >= 'hC000 && ai < 'hE000) begin
                m_vram['h2000 + ai - 'hC000] = d; m_vknown['h2000 + ai - 'hC000] = 1'b1;
                written_q.push_back('h2000 + ai - 'hC000);
            end
        end
        if (!reset) begin
            m_rampage = 0; m_romsel = 0; m_lock = 0; m_conmem = 0;
            m_mapram = 0; m_divpage = 0; m_automap = 0; m_m1on = 0;
            return;
        end
        if (!ce) return;
        if (!iorq && !wr) begin
            if (ai < 'h8000 && ((ai / 2) % 2) == 0 && m_lock == 0) begin
                m_rampage = int'(d) % 8; m_romsel = (int'(d) / 16) % 2; m_lock = (int'(d) / 32) % 2;
            end
            if (ai % 256 == 'hE3) begin
                m_conmem = int'(d) / 128; m_divpage = int'(d) % 32;
                if ((int'(d) / 64) % 2 == 1) m_mapram = 1;
            end
        end
        if (!mreq && !m1) begin
            if (ai == 0 || ai == 'h8 || ai == 'h38 || ai == 'h66 || ai == 'h4C6 || ai == 'h562) n_m1on = 1;
            if (ai >= 'h1FF8 && ai <= 'h1FFF) n_m1on = 0;
            if (ai >= 'h3D00 && ai <= 'h3DFF && m_romsel == 1) begin n_m1on = 1; n_automap = 1; end
        end else if (m1) begin
            n_automap = m_m1on;
        end
        m_m1on = n_m1on;
        m_automap = n_automap;
    endfunction

    // ------------------------------------------------------------------
    // Bus drivers
    // ------------------------------------------------------------------
    task automatic tick();
        @(posedge clock);
        model_step();
        #1;
    endtask

    task automatic idle();
        mreq = 1'b1; iorq = 1'b1; rd = 1'b1; wr = 1'b1; m1 = 1'b1; rfsh = 1'b1;
    endtask

    task automatic mem_rd_drive(input logic [15:0] addr);
        idle(); a = addr; mreq = 1'b0; rd = 1'b0; #1;
    endtask

    task automatic mem_wr_drive(input logic [15:0] addr, input logic [7:0] val);
        idle(); a = addr; d = val; mreq = 1'b0; wr = 1'b0; #1;
    endtask

    task automatic io_out(input logic [15:0] port, input logic [7:0] val);
        idle(); a = port; d = val; iorq = 1'b0; wr = 1'b0;
        tick();
        idle();
        tick();
    endtask

    task automatic fetch_start(input logic [15:0] addr);
        idle(); a = addr; m1 = 1'b0; mreq = 1'b0; rd = 1'b0;
        tick();
    endtask

    task automatic fetch_end();
        m1 = 1'b1; rd = 1'b1; mreq = 1'b0; rfsh = 1'b0; a = 16'h0012;
        tick();
        idle();
        #1;
    endtask

    // ------------------------------------------------------------------
    // Scenarios
    // ------------------------------------------------------------------
    task automatic test_reset();
        idle(); ce = 1'b1; reset = 1'b0;
        tick(); tick();
        n_checks++; if (map !== 1'b0) begin n_fail++; $display("FAIL reset_map_in_reset: got %b want 0", map); end
        reset = 1'b1;
        mem_rd_drive(16'h0000);
        ramQ = 8'h5A; #1;
        n_checks++; if (ramA !== 19'h20000) begin n_fail++; $display("FAIL reset_rd_addr: got %h want 20000", ramA); end
        n_checks++; if (ramRd !== 1'b0) begin n_fail++; $display("FAIL reset_rd_strobe: got %b want 0", ramRd); end
        n_checks++; if (q !== 8'h5A) begin n_fail++; $display("FAIL reset_q_pass: got %h want 5a", q); end
        tick();
        n_checks++; if (map !== 1'b0) begin n_fail++; $display("FAIL reset_map: got %b want 0", map); end
        mem_wr_drive(16'h0000, 8'hC3);
        n_checks++; if (ramWr !== 1'b1) begin n_fail++; $display("FAIL reset_rom_wr_suppressed: got %b want 1", ramWr); end
        n_checks++; if (ramD !== 8'hC3) begin n_fail++; $display("FAIL reset_ramD: got %h want c3", ramD); end
        tick(); idle();
    endtask

    task automatic test_paging();
        io_out(16'h7FFD, 8'h17);
        mem_rd_drive(16'hC000);
        n_checks++; if (ramA !== 19'h1C000) begin n_fail++; $display("FAIL page_c000: got %h want 1c000", ramA); end
        tick();
        mem_rd_drive(16'h0000);
        n_checks++; if (ramA !== 19'h24000) begin n_fail++; $display("FAIL page_rom1: got %h want 24000", ramA); end
        tick();
        mem_rd_drive(16'h8123);
        n_checks++; if (ramA !== 19'h08123) begin n_fail++; $display("FAIL page_bank2: got %h want 08123", ramA); end
        tick(); idle();
    endtask

    task automatic test_automap();
        fetch_start(16'h0038);
        n_checks++; if (map !== 1'b0) begin n_fail++; $display("FAIL am_0038_during: got %b want 0", map); end
        fetch_end();
        n_checks++; if (map !== 1'b1) begin n_fail++; $display("FAIL am_0038_after: got %b want 1", map); end
        fetch_start(16'h1FF8);
        n_checks++; if (map !== 1'b1) begin n_fail++; $display("FAIL am_1ff8_during: got %b want 1", map); end
        fetch_end();
        n_checks++; if (map !== 1'b0) begin n_fail++; $display("FAIL am_1ff8_after: got %b want 0", map); end
        io_out(16'h7FFD, 8'h10);
        fetch_start(16'h3D12);
        n_checks++; if (map !== 1'b1) begin n_fail++; $display("FAIL am_3d12_rom1_during: got %b want 1", map); end
        fetch_end();
        n_checks++; if (map !== 1'b1) begin n_fail++; $display("FAIL am_3d12_rom1_after: got %b want 1", map); end
        fetch_start(16'h1FFF); fetch_end();
        n_checks++; if (map !== 1'b0) begin n_fail++; $display("FAIL am_1fff_after: got %b want 0", map); end
        io_out(16'h7FFD, 8'h00);
        fetch_start(16'h3D12);
        n_checks++; if (map !== 1'b0) begin n_fail++; $display("FAIL am_3d12_rom0_during: got %b want 0", map); end
        fetch_end();
        n_checks++; if (map !== 1'b0) begin n_fail++; $display("FAIL am_3d12_rom0_after: got %b want 0", map); end
    endtask

    task automatic test_divmmc();
        io_out(16'h00E3, 8'h45);
        n_checks++; if (map !== 1'b0) begin n_fail++; $display("FAIL dm_e3_45_map: got %b want 0", map); end
        fetch_start(16'h0038); fetch_end();
        mem_rd_drive(16'h0100);
        n_checks++; if (ramA !== 19'h46100) begin n_fail++; $display("FAIL dm_mapram_rd: got %h want 46100", ramA); end
        n_checks++; if (ramRd !== 1'b0) begin n_fail++; $display("FAIL dm_mapram_rd_strobe: got %b want 0", ramRd); end
        tick();
        mem_wr_drive(16'h0100, 8'h11);
        n_checks++; if (ramWr !== 1'b1) begin n_fail++; $display("FAIL dm_mapram_wr_suppressed: got %b want 1", ramWr); end
        tick();
        mem_wr_drive(16'h2100, 8'h22);
        n_checks++; if (ramA !== 19'h4A100) begin n_fail++; $display("FAIL dm_page5_addr: got %h want 4a100", ramA); end
        n_checks++; if (ramWr !== 1'b0) begin n_fail++; $display("FAIL dm_page5_wr: got %b want 0", ramWr); end
        tick();
        io_out(16'h00E3, 8'h00);
        mem_rd_drive(16'h0100);
        n_checks++; if (ramA !== 19'h46100) begin n_fail++; $display("FAIL dm_mapram_sticky: got %h want 46100", ramA); end
        tick();
        fetch_start(16'h1FF8); fetch_end();
        io_out(16'h00E3, 8'h9F);
        n_checks++; if (map !== 1'b1) begin n_fail++; $display("FAIL dm_conmem_map: got %b want 1", map); end
        mem_wr_drive(16'h2000, 8'h33);
        n_checks++; if (ramA !== 19'h7E000) begin n_fail++; $display("FAIL dm_page31_addr: got %h want 7e000", ramA); end
        n_checks++; if (ramWr !== 1'b0) begin n_fail++; $display("FAIL dm_page31_wr: got %b want 0", ramWr); end
        tick();
        io_out(16'h00E3, 8'h00);
        n_checks++; if (map !== 1'b0) begin n_fail++; $display("FAIL dm_conmem_off: got %b want 0", map); end
    endtask

    task automatic test_vram();
        mem_wr_drive(16'h4123, 8'hAA);
        n_checks++; if (ramA !== 19'h14123) begin n_fail++; $display("FAIL vr_bank5_addr: got %h want 14123", ramA); end
        tick(); idle();
        va = 14'h0123; vce = 1'b1; tick(); vce = 1'b0;
        n_checks++; if (vq !== 8'hAA) begin n_fail++; $display("FAIL vr_bank5_read: got %h want aa", vq); end
        io_out(16'h7FFD, 8'h07);
        mem_wr_drive(16'hC010, 8'h5C);
        n_checks++; if (ramA !== 19'h1C010) begin n_fail++; $display("FAIL vr_bank7_addr: got %h want 1c010", ramA); end
        tick(); idle();
        va = 14'h2010; vce = 1'b1; tick(); vce = 1'b0;
        n_checks++; if (vq !== 8'h5C) begin n_fail++; $display("FAIL vr_bank7_read: got %h want 5c", vq); end
        va = 14'h0123; tick();
        n_checks++; if (vq !== 8'h5C) begin n_fail++; $display("FAIL vr_hold_without_vce: got %h want 5c", vq); end
        mem_wr_drive(16'h4155, 8'h3E); tick(); idle();
        a = 16'h4055; mreq = 1'b0; rfsh = 1'b0; va = 14'h0123; vce = 1'b1;
        tick(); vce = 1'b0; idle();
        n_checks++; if (vq !== 8'h3E) begin n_fail++; $display("FAIL vr_snow_read: got %h want 3e", vq); end
        io_out(16'h7FFD, 8'h00);
    endtask

    task automatic test_random();
        int op, ai, pick;
        logic [7:0] dv;
        for (int it = 0; it < 400; it++) begin
            op   = $urandom_range(0, 5);
            dv   = 8'($urandom);
            ce   = ($urandom_range(0, 3) != 0);
            ramQ = 8'($urandom);
            case (op)
                0: begin
                    ai = $urandom_range(0, 65535);
                    mem_rd_drive(16'(ai));
                    n_checks++; if (ramA !== 19'(exp_addr(ai))) begin n_fail++; $display("FAIL rnd_rd_addr a=%h: got %h want %h", ai, ramA, 19'(exp_addr(ai))); end
                    n_checks++; if (ramRd !== 1'b0 || q !== ramQ) begin n_fail++; $display("FAIL rnd_rd_strobe: got rd=%b q=%h want 0 %h", ramRd, q, ramQ); end
                    tick();
                end
                1: begin
                    pick = $urandom_range(0, 3);
                    if (pick == 0)      ai = 'h4000 + $urandom_range(0, 'h1FFF);
                    else if (pick == 1) ai = 'hC000 + $urandom_range(0, 'h1FFF);
                    else                ai = $urandom_range(0, 65535);
                    mem_wr_drive(16'(ai), dv);
                    n_checks++; if (ramA !== 19'(exp_addr(ai))) begin n_fail++; $display("FAIL rnd_wr_addr a=%h: got %h want %h", ai, ramA, 19'(exp_addr(ai))); end
                    n_checks++; if (ramWr !== !exp_writable(ai)) begin n_fail++; $display("FAIL rnd_wr_strobe a=%h: got %b want %b", ai, ramWr, !exp_writable(ai)); end
                    tick();
                end
                2: begin
                    pick = $urandom_range(0, 3);
                    if (pick == 0)      ai = 'h7FFD;
                    else if (pick == 1) ai = 'h00E3 + 256 * $urandom_range(0, 255);
                    else                ai = $urandom_range(0, 65535);
                    dv[5] = 1'b0;
                    io_out(16'(ai), dv);
                    n_checks++; if (map !== exp_map()) begin n_fail++; $display("FAIL rnd_io_map port=%h d=%h: got %b want %b", ai, dv, map, exp_map()); end
                end
                3: begin
                    pick = $urandom_range(0, 5);
                    if (pick == 0)      ai = 'h0038;
                    else if (pick == 1) ai = 'h0562;
                    else if (pick == 2) ai = 'h1FF8 + $urandom_range(0, 7);
                    else if (pick == 3) ai = 'h3D00 + $urandom_range(0, 255);
                    else                ai = $urandom_range(0, 65535);
                    fetch_start(16'(ai));
                    n_checks++; if (map !== exp_map()) begin n_fail++; $display("FAIL rnd_fetch_during a=%h: got %b want %b", ai, map, exp_map()); end
                    fetch_end();
                    n_checks++; if (map !== exp_map()) begin n_fail++; $display("FAIL rnd_fetch_after a=%h: got %b want %b", ai, map, exp_map()); end
                end
                default: begin
                    idle();
                    if (written_q.size() > 0) va = 14'(written_q[$urandom_range(0, written_q.size() - 1)]);
                    else                      va = 14'($urandom);
                    if ($urandom_range(0, 3) == 0) begin
                        a = 16'('h4000 + $urandom_range(0, 'h3FFF)); mreq = 1'b0; rfsh = 1'b0;
                    end
                    vce = 1'b1; tick(); vce = 1'b0;
                    if (m_vq_known) begin
                        n_checks++; if (vq !== m_vq) begin n_fail++; $display("FAIL rnd_vram va=%h: got %h want %h", va, vq, m_vq); end
                    end
                end
            endcase
            idle();
        end
        ce = 1'b1;
    endtask

    task automatic test_lock();
        io_out(16'h00E3, 8'h00);
        fetch_start(16'h1FF8); fetch_end();
        io_out(16'h7FFD, 8'h20);
        mem_rd_drive(16'hC000);
        n_checks++; if (ramA !== 19'h00000) begin n_fail++; $display("FAIL lock_set_page0: got %h want 00000", ramA); end
        tick();
        mem_rd_drive(16'h0000);
        n_checks++; if (ramA !== 19'h20000) begin n_fail++; $display("FAIL lock_set_rom0: got %h want 20000", ramA); end
        tick();
        io_out(16'h7FFD, 8'h03);
        mem_rd_drive(16'hC000);
        n_checks++; if (ramA !== 19'h00000) begin n_fail++; $display("FAIL lock_held_page: got %h want 00000", ramA); end
        tick();
        io_out(16'h7FFD, 8'h17);
        mem_rd_drive(16'h0000);
        n_checks++; if (ramA !== 19'h20000) begin n_fail++; $display("FAIL lock_held_rom: got %h want 20000", ramA); end
        tick(); idle();
    endtask

    task automatic test_reset_mid();
        io_out(16'h00E3, 8'h80);
        mem_rd_drive(16'h0000);
        n_checks++; if (ramA !== 19'h46000) begin n_fail++; $display("FAIL rm_before: got %h want 46000", ramA); end
        reset = 1'b0;
        tick();
        n_checks++; if (map !== 1'b0) begin n_fail++; $display("FAIL rm_map_cleared: got %b want 0", map); end
        n_checks++; if (ramA !== 19'h20000) begin n_fail++; $display("FAIL rm_decode_after: got %h want 20000", ramA); end
        reset = 1'b1; idle(); tick();
        io_out(16'h7FFD, 8'h01);
        mem_rd_drive(16'hC000);
        n_checks++; if (ramA !== 19'h04000) begin n_fail++; $display("FAIL rm_lock_cleared: got %h want 04000", ramA); end
        tick(); idle();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        idle();
        reset = 1'b0; ce = 1'b1; vce = 1'b0; va = '0; a = '0; d = '0; ramQ = '0;
        test_reset();
        test_paging();
        test_automap();
        test_divmmc();
        test_vram();
        test_random();
        test_lock();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
